axis_packet_arbiter: RTL

Packet-level round-robin arbiter that shares one AXI-Stream master port between `NUM_S` AXI-Stream slave ports. It sits between several stream producers (e.g. per-row result streams of the systolic array) and a single output DMA/sink.
- A grant is held for a whole packet, from the first beat to the `last` beat, so packets never interleave.
- Data moves combinationally through the granted path.
- The only sequential element on the data path is the grant/state register.

---
 rtl/axis_pkg.sv | 15 +
 rtl/axis_packet_arbiter_if.sv | 39 +++
 rtl/rr_pick.sv | 43 ++++
 rtl/axis_packet_arbiter.sv | 110 +++++++++++
 4 files changed

// File: rtl/axis_pkg.sv
// Shared types and helpers for the packet arbiter slice.
package axis_pkg;

    // IDLE: no packet owns the output. BUSY: the input in grant owns it until its last beat.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Number of words carried by one bus beat.
    function automatic int words_per_beat(input int bus_w, input int word_w);
        return bus_w / word_w;
    endfunction

endpackage

// File: rtl/axis_packet_arbiter_if.sv
// Bundle of the NUM_S input streams and the single output stream of the arbiter.
interface axis_packet_arbiter_if #(
    parameter int NUM_S      = 4,
    parameter int WORD_WIDTH = 8,
    parameter int BUS_WIDTH  = 8
);
    import axis_pkg::*;

    localparam int WORDS_PER_BEAT = words_per_beat(BUS_WIDTH, WORD_WIDTH);
    localparam int ID_W           = $clog2(NUM_S);

    // Input (slave-side) streams, one lane per producer.
    logic [NUM_S-1:0]                                      s_valid;
    logic [NUM_S-1:0]                                      s_ready;
    logic [NUM_S-1:0]                                      s_last;
    logic [NUM_S-1:0][WORDS_PER_BEAT-1:0][WORD_WIDTH-1:0] s_data;
    logic [NUM_S-1:0][WORDS_PER_BEAT-1:0]                  s_keep;

    // Shared output (master-side) stream.
    logic                                   m_ready;
    logic                                   m_valid;
    logic                                   m_last;
    logic [WORDS_PER_BEAT-1:0][WORD_WIDTH-1:0] m_data;
    logic [WORDS_PER_BEAT-1:0]              m_keep;
    logic [ID_W-1:0]                        m_id;

    // Arbiter view: it owns the output stream and the input readies.
    modport master (
        input  s_valid, s_last, s_data, s_keep, m_ready,
        output s_ready, m_valid, m_last, m_data, m_keep, m_id
    );

    // Environment view: producers drive the inputs, the sink drives m_ready.
    modport slave (
        output s_valid, s_last, s_data, s_keep, m_ready,
        input  s_ready, m_valid, m_last, m_data, m_keep, m_id
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: rotate requests so that the slot after
// i_last_grant sits at bit 0, take the lowest set bit, then rotate back.
module rr_pick #(
    parameter int NUM_S = 4,
    parameter int ID_W  = $clog2(NUM_S)
) (
    input  logic [NUM_S-1:0] i_req,
    input  logic [ID_W-1:0]  i_last_grant,
    output logic             o_any,
    output logic [ID_W-1:0]  o_winner
);

    localparam logic [ID_W:0] NUM_S_W = (ID_W+1)'(NUM_S);

    logic [ID_W:0]      w_start;     // first slot to consider, 1..NUM_S
    logic [2*NUM_S-1:0] w_req_dbl;
    logic [NUM_S-1:0]   w_rot;
    logic [ID_W-1:0]    w_offset;
    logic [ID_W:0]      w_sum;

    assign w_start   = {1'b0, i_last_grant} + (ID_W+1)'(1);
    assign w_req_dbl = {i_req, i_req};
    // Shifting the doubled vector implements a rotate for any NUM_S, not just powers of two.
    assign w_rot     = NUM_S'(w_req_dbl >> w_start);
    assign o_any     = |i_req;

    // Priority-encode the lowest set bit of the rotated request vector.
    always_comb begin
        w_offset = '0;
        for (int i = NUM_S - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_offset = ID_W'(i);
            end
        end
    end

    // Un-rotate the encoded offset back into an absolute input index.
    always_comb begin
        w_sum    = w_start + {1'b0, w_offset};
        o_winner = ID_W'((w_sum >= NUM_S_W) ? (w_sum - NUM_S_W) : w_sum);
    end

endmodule

// File: rtl/axis_packet_arbiter.sv
// Packet-level round-robin arbiter: NUM_S AXI-Stream inputs share one output.
// A grant is held from first beat to last beat; the data path is purely combinational.
module axis_packet_arbiter
    import axis_pkg::*;
#(
    parameter int NUM_S      = 4,
    parameter int WORD_WIDTH = 8,
    parameter int BUS_WIDTH  = 8
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    axis_packet_arbiter_if.master bus
);

    localparam int WORDS_PER_BEAT = words_per_beat(BUS_WIDTH, WORD_WIDTH);
    localparam int ID_W           = $clog2(NUM_S);

    arb_state_t      r_state, w_state_next;
    logic [ID_W-1:0] r_grant, w_grant_next;
    logic [ID_W-1:0] r_last_grant, w_last_grant_next;

    logic [NUM_S-1:0] w_grant_onehot;
    logic [NUM_S-1:0] w_pick_req;
    logic [ID_W-1:0]  w_pick_base;
    logic             w_any;
    logic [ID_W-1:0]  w_winner;
    logic             w_pkt_end;

    logic [WORDS_PER_BEAT-1:0][WORD_WIDTH-1:0] w_m_data;
    logic [WORDS_PER_BEAT-1:0]                 w_m_keep;

    assign w_grant_onehot = NUM_S'(1) << r_grant;
    assign w_pkt_end      = (r_state == BUSY) && bus.s_valid[r_grant]
                            && bus.m_ready && bus.s_last[r_grant];

    // At a packet end the current owner's valid belongs to the beat being consumed,
    // not to a new request, so it is masked; the owner also becomes the rotation base
    // and therefore the lowest priority for the next packet.
    assign w_pick_req  = (r_state == BUSY) ? (bus.s_valid & ~w_grant_onehot) : bus.s_valid;
    assign w_pick_base = (r_state == BUSY) ? r_grant : r_last_grant;

    rr_pick #(
        .NUM_S (NUM_S),
        .ID_W  (ID_W)
    ) u_rr_pick (
        .i_req        (w_pick_req),
        .i_last_grant (w_pick_base),
        .o_any        (w_any),
        .o_winner     (w_winner)
    );

    // Next state: grant on any request from IDLE, re-arbitrate in the same edge at packet end.
    always_comb begin
        w_state_next      = r_state;
        w_grant_next      = r_grant;
        w_last_grant_next = r_last_grant;
        unique case (r_state)
            IDLE: begin
                if (w_any) begin
                    w_grant_next = w_winner;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                if (w_pkt_end) begin
                    w_last_grant_next = r_grant;
                    if (w_any) begin
                        w_grant_next = w_winner;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State and grant registers; reset makes input 0 the first in line.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state      <= IDLE;
            r_grant      <= '0;
            r_last_grant <= ID_W'(NUM_S - 1);
        end else begin
            r_state      <= w_state_next;
            r_grant      <= w_grant_next;
            r_last_grant <= w_last_grant_next;
        end
    end

    // Output mux: only the granted input reaches the output and sees m_ready.
    always_comb begin
        bus.s_ready  = '0;
        bus.m_valid  = 1'b0;
        bus.m_last   = 1'b0;
        w_m_data     = '0;
        w_m_keep     = '0;
        if (r_state == BUSY) begin
            bus.m_valid = bus.s_valid[r_grant];
            bus.m_last  = bus.s_last[r_grant];
            w_m_data    = bus.s_data[r_grant];
            w_m_keep    = bus.s_keep[r_grant];
            bus.s_ready = bus.m_ready ? w_grant_onehot : '0;
        end
        bus.m_data = w_m_data;
        bus.m_keep = w_m_keep;
        bus.m_id   = r_grant;
    end

endmodule
